// File: rtl/op_issuer.sv
// -----------------------------------------------------------------------------
// op_issuer
//
// Turns host commands and a host write-data stream into the operation/in_data
// word sequence that the W/X memory + m8x8 multiplier controller expects.
//
//   opcode 0  : no-op, acknowledged with a done pulse
//   opcode 1  : multiply; the command word is held on `operation` for exactly
//               WLEN*XLINES enabled cycles, followed by DRAIN idle cycles so
//               y write-back completes and the next multiply sees a fresh
//               rising edge of opcode 1
//   opcode 2  : page write; one operation word per accepted data beat, zero
//               on stall cycles, WR_WORDS beats in total, then one idle cycle
//   3..15     : rejected with an err pulse, no output activity
//
// Ports
//   clk         clock, all state on posedge
//   reset       asynchronous active-high reset, clears all state
//   enable      global enable; low freezes state/counters/outputs
//   cmd_valid   host command valid
//   cmd_ready   command accepted when high (IDLE and enabled)
//   cmd_op      [3:0] opcode, [7:4] a, [11:8] b, [15:12] c (fields unchecked)
//   data_valid  host write-data valid
//   data_ready  write word accepted when high (WRITE, beats left, enabled)
//   data_in     host write word
//   operation   registered operation word to controller, [31:16] always 0
//   in_data     registered write data to controller
//   busy        high whenever a command is in progress
//   done        one-cycle pulse on command completion
//   err         one-cycle pulse on an illegal opcode
// -----------------------------------------------------------------------------
module op_issuer #(
    parameter int WLEN     = 32,
    parameter int XLINES   = 2,
    parameter int WR_WORDS = 64,
    parameter int DRAIN    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_op,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic [31:0] data_in,
    output logic [31:0] operation,
    output logic [31:0] in_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int MULT_CYCLES = WLEN * XLINES;
    localparam int MW = $clog2(MULT_CYCLES + 1);
    localparam int DW = $clog2(DRAIN + 1);
    localparam int BW = $clog2(WR_WORDS + 1);

    localparam logic [MW-1:0] MULT_LAST  = MW'(MULT_CYCLES);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN);
    localparam logic [BW-1:0] BEATS_ALL  = BW'(WR_WORDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MULT  = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t        state;
    logic [MW-1:0] mult_cnt;
    logic [DW-1:0] drain_cnt;
    logic [BW-1:0] beat_cnt;
    logic [15:0]   cmd_word;   // latched command, replayed on every write beat
    logic [15:0]   op_word;    // low half of the operation register
    logic [31:0]   in_word;
    logic          done_q;
    logic          err_q;

    // Handshake readiness. data_ready drops as soon as the final beat has been
    // taken (beat_cnt == WR_WORDS) so no extra word can slip in.
    assign cmd_ready  = enable && (state == S_IDLE);
    assign data_ready = enable && (state == S_WRITE) && (beat_cnt != BEATS_ALL);

    assign operation = {16'h0000, op_word};
    assign in_data   = in_word;
    assign busy      = (state != S_IDLE);

    // The pulse registers keep their value while disabled so a completion that
    // lands just before enable drops is reported once enable returns; the
    // outputs themselves are forced low while disabled.
    assign done = done_q && enable;
    assign err  = err_q && enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            mult_cnt  <= '0;
            drain_cnt <= '0;
            beat_cnt  <= '0;
            cmd_word  <= '0;
            op_word   <= '0;
            in_word   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else if (enable) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;

            case (state)
                S_IDLE: begin
                    // cmd_ready is implied here: IDLE with enable high.
                    if (cmd_valid) begin
                        case (cmd_op[3:0])
                            4'd0: begin
                                done_q <= 1'b1;
                            end
                            4'd1: begin
                                // The word becomes visible after this edge,
                                // which is the first of the MULT_CYCLES cycles.
                                state    <= S_MULT;
                                cmd_word <= cmd_op;
                                op_word  <= cmd_op;
                                mult_cnt <= MW'(1);
                            end
                            4'd2: begin
                                // operation stays 0 until the first beat.
                                state    <= S_WRITE;
                                cmd_word <= cmd_op;
                                beat_cnt <= '0;
                            end
                            default: begin
                                err_q <= 1'b1;
                            end
                        endcase
                    end
                end

                S_MULT: begin
                    // mult_cnt = number of cycles the word has been shown,
                    // including the one that ends at this edge.
                    if (mult_cnt == MULT_LAST) begin
                        op_word   <= '0;
                        state     <= S_DRAIN;
                        drain_cnt <= DW'(1);
                    end else begin
                        mult_cnt <= mult_cnt + MW'(1);
                    end
                end

                S_DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end

                S_WRITE: begin
                    if (beat_cnt == BEATS_ALL) begin
                        // The final word was shown for one cycle; close it.
                        op_word <= '0;
                        state   <= S_GAP;
                    end else if (data_valid) begin
                        op_word  <= cmd_word;
                        in_word  <= data_in;
                        beat_cnt <= beat_cnt + BW'(1);
                    end else begin
                        // Stall: zero operation so the controller never
                        // writes a stale in_data word; in_data holds.
                        op_word <= '0;
                    end
                end

                S_GAP: begin
                    state  <= S_IDLE;
                    done_q <= 1'b1;
                end

                default: begin
                    state   <= S_IDLE;
                    op_word <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_op_issuer.sv
// -----------------------------------------------------------------------------
// tb_op_issuer
//
// Directed + randomized bench for op_issuer with default parameters
// (64-cycle multiply burst, 16-cycle drain, 64-beat page write).
// Expected outputs come from closed-form rules: for a multiply the phase is a
// function of how many enabled edges have elapsed since acceptance; for a
// write the expected words are the beats the bench itself handed over.
// -----------------------------------------------------------------------------
module tb_op_issuer;

    localparam int N  = 64;   // WLEN * XLINES
    localparam int DR = 16;   // DRAIN
    localparam int WW = 64;   // WR_WORDS

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_op;
    logic        data_valid;
    logic        data_ready;
    logic [31:0] data_in;
    logic [31:0] operation;
    logic [31:0] in_data;
    logic        busy;
    logic        done;
    logic        err;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_in;      // in_data is expected to hold the last beat taken

    op_issuer #(
        .WLEN    (32),
        .XLINES  (2),
        .WR_WORDS(WW),
        .DRAIN   (DR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .data_in   (data_in),
        .operation (operation),
        .in_data   (in_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called 1 time unit after an edge in IDLE; returns 1 time unit after the
    // accepting edge, ready to drive the inputs of the first cycle after it.
    task automatic issue(input logic [15:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        #1;
        chk1("issue_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op    = 16'($urandom);
    endtask

    // mode 0: always enabled; 1: enable low for cycles 20..29; 2: random enable
    task automatic run_mult(input logic [15:0] op, input int mode);
        int   p;
        int   e;
        int   done_at;
        logic en;
        logic fin;
        p = 0; e = 0; done_at = -1; fin = 1'b0;
        issue(op);
        while (!fin && e < 500) begin
            case (mode)
                1:       en = !(e >= 20 && e < 30);
                2:       en = ($urandom_range(0, 3) != 0);
                default: en = 1'b1;
            endcase
            enable = en;
            #1;
            // p = enabled edges since the word first appeared
            chk("mult_op", operation, (p < N) ? {16'h0000, op} : 32'h0);
            chk("mult_in_data", in_data, exp_in);
            chk1("mult_busy", busy, p < N + DR);
            chk1("mult_done", done, (p == N + DR) && en);
            chk1("mult_cmd_ready", cmd_ready, (p >= N + DR) && en);
            chk1("mult_data_ready", data_ready, 1'b0);
            chk1("mult_err", err, 1'b0);
            if (p == N + DR && en) begin
                fin = 1'b1;
                done_at = e;
            end
            if (en) p++;
            @(posedge clk); #1;
            e++;
        end
        enable = 1'b1;
        chk1("mult_completed", fin, 1'b1);
        if (mode == 0) chk("mult_done_cycle", done_at, N + DR);
        if (mode == 1) chk("mult_done_delayed", done_at, N + DR + 10);
    endtask

    // mode 0: data 0..63 with data_valid low every 5th cycle; 1: random
    task automatic run_write(input logic [15:0] op, input int mode);
        int          beats;
        int          e;
        int          last_e;
        int          word_k;
        int          op_cycles;
        logic        beat_prev;
        logic        beat_now;
        logic        fin;
        logic        tail_idle;
        beats = 0; e = 0; last_e = 1 << 20; word_k = 0; op_cycles = 0;
        beat_prev = 1'b0; fin = 1'b0;
        issue(op);
        while (!fin && e < 1000) begin
            if (beats < WW) begin
                data_valid = (mode == 0) ? (e % 5 != 4) : ($urandom_range(0, 2) != 0);
                data_in    = (mode == 0 && data_valid) ? 32'(word_k) : $urandom;
            end else begin
                data_valid = 1'($urandom_range(0, 1));
                data_in    = $urandom;
            end
            #1;
            tail_idle = (beats == WW) && (e - last_e >= 2);
            chk("write_op", operation, beat_prev ? {16'h0000, op} : 32'h0);
            chk("write_in_data", in_data, exp_in);
            chk1("write_data_ready", data_ready, beats < WW);
            chk1("write_busy", busy, !tail_idle);
            chk1("write_done", done, tail_idle);
            chk1("write_cmd_ready", cmd_ready, tail_idle);
            chk1("write_err", err, 1'b0);
            if (operation == {16'h0000, op}) op_cycles++;
            if (tail_idle) fin = 1'b1;
            beat_now = (beats < WW) && data_valid;
            if (beat_now) begin
                beats++;
                word_k++;
                exp_in = data_in;
                if (beats == WW) last_e = e + 1;
            end
            beat_prev = beat_now;
            @(posedge clk); #1;
            e++;
        end
        data_valid = 1'b0;
        chk1("write_completed", fin, 1'b1);
        chk("write_op_cycles", op_cycles, WW);
    endtask

    initial begin
        logic [15:0] op;
        int          gap;
        int          burst1;
        int          burst2;
        int          done_cnt;

        reset = 1'b1; enable = 1'b1; cmd_valid = 1'b0; cmd_op = 16'h0;
        data_valid = 1'b0; data_in = 32'h0; exp_in = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_operation", operation, 32'h0);
        chk("rst_in_data", in_data, 32'h0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_cmd_ready", cmd_ready, 1'b1);
        chk1("rst_data_ready", data_ready, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Opcode 0: done next cycle, nothing else moves
        issue(16'h0a70);
        #1;
        chk1("nop_done", done, 1'b1);
        chk1("nop_err", err, 1'b0);
        chk1("nop_busy", busy, 1'b0);
        chk("nop_operation", operation, 32'h0);
        @(posedge clk); #1; #1;
        chk1("nop_done_pulse", done, 1'b0);
        @(posedge clk); #1;

        // Illegal opcodes: directed 5, then random 3..15
        for (int i = 0; i < 6; i++) begin
            op = (i == 0) ? 16'h0005 : {12'($urandom), 4'($urandom_range(3, 15))};
            issue(op);
            #1;
            chk1("ill_err", err, 1'b1);
            chk1("ill_done", done, 1'b0);
            chk1("ill_busy", busy, 1'b0);
            chk("ill_operation", operation, 32'h0);
            @(posedge clk); #1; #1;
            chk1("ill_err_pulse", err, 1'b0);
            chk1("ill_busy_after", busy, 1'b0);
            @(posedge clk); #1;
        end

        // Single multiply, continuously enabled
        run_mult(16'h0231, 0);

        // Two multiplies back to back with cmd_valid held
        gap = 0; burst1 = 0; burst2 = 0; done_cnt = 0;
        cmd_op = 16'h0231;
        cmd_valid = 1'b1;
        #1;
        chk1("b2b_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk); #1;
        for (int e = 0; e <= 170; e++) begin
            cmd_valid = (e <= 80);
            #1;
            chk("b2b_op", operation,
                ((e < 64) || (e >= 81 && e < 145)) ? 32'h0000_0231 : 32'h0);
            chk1("b2b_done", done, (e == 80) || (e == 161));
            chk1("b2b_busy", busy, !((e == 80) || (e >= 161)));
            if (operation != 32'h0) begin
                if (gap > 0) burst2++;
                else burst1++;
            end else if (burst1 > 0 && burst2 == 0) begin
                gap++;
            end
            if (done) done_cnt++;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        chk("b2b_burst1", burst1, N);
        chk("b2b_burst2", burst2, N);
        chk1("b2b_gap_min", gap >= DR, 1'b1);
        chk("b2b_done_pulses", done_cnt, 2);

        // Multiply with a 10-cycle enable drop
        run_mult(16'h0231, 1);

        // Page write: directed then random
        run_write(16'h0082, 0);
        run_write({12'($urandom), 4'd2}, 1);

        // Random-enable multiplies (in_data must still hold the last beat)
        for (int i = 0; i < 2; i++) run_mult({12'($urandom), 4'd1}, 2);

        // Back-to-back write then multiply, random fields
        run_write({12'($urandom), 4'd2}, 1);
        run_mult({12'($urandom), 4'd1}, 0);

        // Reset in the middle of a multiply
        issue(16'h0231);
        for (int e = 0; e < 20; e++) begin
            #1;
            chk("rmid_op_before", operation, 32'h0000_0231);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        exp_in = 32'h0;
        #1;
        chk("rmid_op", operation, 32'h0);
        chk("rmid_in_data", in_data, exp_in);
        chk1("rmid_busy", busy, 1'b0);
        chk1("rmid_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rmid_op_edge", operation, 32'h0);
        chk1("rmid_busy_edge", busy, 1'b0);
        chk1("rmid_cmd_ready_edge", cmd_ready, 1'b1);
        @(posedge clk); #1;
        for (int e = 0; e < 100; e++) begin
            #1;
            chk1("rmid_no_done", done, 1'b0);
            chk("rmid_op_idle", operation, 32'h0);
            chk1("rmid_busy_idle", busy, 1'b0);
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
